// File: rtl/booth_operand_sequencer.sv
// booth_operand_sequencer
// Feeds a multi-cycle Booth multiplier from a small operand FIFO. Operand
// pairs arrive on a valid/ready port and are buffered. One job at a time is
// issued to the multiplier with a single-cycle mul_load pulse. The block
// waits out the multiplier's fixed latency, captures the product, and holds
// it on a valid/ready result port until the consumer takes it.

module booth_operand_sequencer #(
  parameter int WIDTH      = 4,
  parameter int DEPTH      = 4,
  parameter int MUL_CYCLES = 6
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [WIDTH-1:0]         in_m,
  input  logic [WIDTH-1:0]         in_q,
  output logic                     mul_load,
  output logic [WIDTH-1:0]         mul_M,
  output logic [WIDTH-1:0]         mul_Q,
  input  logic [2*WIDTH-1:0]       mul_P,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [2*WIDTH-1:0]       out_p,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Operand storage; contents are don't-care until written, so no reset.
  logic [WIDTH-1:0] fifo_m_q [DEPTH];
  logic [WIDTH-1:0] fifo_q_q [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic mul_load_q, mul_load_d;
  logic [WIDTH-1:0] mul_m_q, mul_m_d;
  logic [WIDTH-1:0] mul_q_q, mul_q_d;
  logic out_valid_q, out_valid_d;
  logic [2*WIDTH-1:0] out_p_q, out_p_d;

  logic push;
  logic pop;

  // Readiness comes from the registered level only, so a pop never frees
  // space for a push in the same cycle.
  assign in_ready = (level_q != LVL_W'(DEPTH));
  assign push     = in_valid & in_ready;

  assign mul_load  = mul_load_q;
  assign mul_M     = mul_m_q;
  assign mul_Q     = mul_q_q;
  assign out_valid = out_valid_q;
  assign out_p     = out_p_q;
  assign busy      = (state_q != IDLE);
  assign level     = level_q;

  // FIFO pointer and occupancy bookkeeping; pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    unique case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  // Job sequencing: pop a pair, pulse load, count out the latency, then
  // hold the result until the consumer accepts it.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_load_d  = 1'b0;
    mul_m_d     = mul_m_q;
    mul_q_d     = mul_q_q;
    out_valid_d = out_valid_q;
    out_p_d     = out_p_q;
    pop         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          pop        = 1'b1;
          mul_m_d    = fifo_m_q[rd_ptr_q];
          mul_q_d    = fifo_q_q[rd_ptr_q];
          mul_load_d = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        cnt_d   = CNT_W'(MUL_CYCLES - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          out_p_d     = mul_P;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Capture incoming operand pairs at the write pointer.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_m_q[wr_ptr_q] <= in_m;
      fifo_q_q[wr_ptr_q] <= in_q;
    end
  end

  // FIFO control registers; reset drops any buffered pairs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  // Sequencer state and multiplier/result registers; reset abandons a job.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      mul_load_q  <= 1'b0;
      mul_m_q     <= '0;
      mul_q_q     <= '0;
      out_valid_q <= 1'b0;
      out_p_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mul_load_q  <= mul_load_d;
      mul_m_q     <= mul_m_d;
      mul_q_q     <= mul_q_d;
      out_valid_q <= out_valid_d;
      out_p_q     <= out_p_d;
    end
  end

endmodule

// File: tb/tb_booth_operand_sequencer.sv
// Testbench for booth_operand_sequencer. A behavioural multiplier drives
// mul_P with the true product only on the single cycle the sequencer should
// sample it, and with a scrambled value on every other cycle.

module tb_booth_operand_sequencer;

  localparam int WIDTH      = 4;
  localparam int DEPTH      = 4;
  localparam int MUL_CYCLES = 6;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_m;
  logic [3:0] in_q;
  logic       mul_load;
  logic [3:0] mul_M;
  logic [3:0] mul_Q;
  logic [7:0] mul_P;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_p;
  logic       busy;
  logic [2:0] level;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  booth_operand_sequencer #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .MUL_CYCLES(MUL_CYCLES)
  ) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
    .mul_load(mul_load), .mul_M(mul_M), .mul_Q(mul_Q), .mul_P(mul_P),
    .out_valid(out_valid), .out_ready(out_ready), .out_p(out_p),
    .busy(busy), .level(level)
  );

  always #5 clk = ~clk;

  // Cycle counter used to measure latencies.
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural multiplier: product valid exactly MUL_CYCLES after load.
  logic [3:0]        mod_m = 4'h0;
  logic [3:0]        mod_q = 4'h0;
  int                mcnt  = 0;
  logic signed [7:0] ext_m, ext_q, mod_prod;

  always @(posedge clk) begin
    if (mul_load === 1'b1) begin
      mod_m <= mul_M;
      mod_q <= mul_Q;
      mcnt  <= 1;
    end else if (mcnt != 0 && mcnt < MUL_CYCLES) begin
      mcnt <= mcnt + 1;
    end else begin
      mcnt <= 0;
    end
  end

  always_comb begin
    ext_m    = {{4{mod_m[3]}}, mod_m};
    ext_q    = {{4{mod_q[3]}}, mod_q};
    mod_prod = ext_m * ext_q;
  end

  assign mul_P = (mcnt == MUL_CYCLES) ? mod_prod : (~mod_prod ^ 8'(mcnt));

  // Passive monitor: accepted results, load pulses, operand stability, peak level.
  logic [7:0] res_q[$];
  int         res_cyc[$];
  int         load_cyc[$];
  int         max_level  = 0;
  int         stable_err = 0;
  bit         in_job     = 1'b0;
  logic [3:0] hold_m, hold_q;

  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (out_valid && out_ready) begin
        res_q.push_back(out_p);
        res_cyc.push_back(cyc);
      end
      if (mul_load) begin
        load_cyc.push_back(cyc);
        hold_m = mul_M;
        hold_q = mul_Q;
        in_job = 1'b1;
      end else if (in_job && busy && !out_valid) begin
        if (mul_M !== hold_m || mul_Q !== hold_q) stable_err++;
      end
      if (out_valid) in_job = 1'b0;
      if (int'(level) > max_level) max_level = int'(level);
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation did not complete");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    res_q.delete();
    res_cyc.delete();
    load_cyc.delete();
    max_level  = 0;
    stable_err = 0;
    in_job     = 1'b0;
  endtask

  task automatic wait_results(input int n, input int budget);
    int k = 0;
    while (res_q.size() < n && k < budget) begin
      step();
      k++;
    end
    repeat (3) step();
  endtask

  function automatic logic [7:0] get_res(input int i);
    if (i < res_q.size()) return res_q[i];
    return 8'hxx;
  endfunction

  function automatic int get_res_cyc(input int i);
    if (i < res_cyc.size()) return res_cyc[i];
    return -1000;
  endfunction

  function automatic int get_load_cyc(input int i);
    if (i < load_cyc.size()) return load_cyc[i];
    return -1000;
  endfunction

  task automatic test_reset();
    reset = 1'b0; in_valid = 1'b0; in_m = '0; in_q = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (mul_load !== 1'b0) begin failures++; $display("[TB] FAIL reset_mul_load: got %b expected 0", mul_load); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (level !== 3'd0) begin failures++; $display("[TB] FAIL reset_level: got %0d expected 0", level); end
    checks++; if (out_p !== 8'h00) begin failures++; $display("[TB] FAIL reset_out_p: got %h expected 00", out_p); end
    checks++; if (mul_M !== 4'h0 || mul_Q !== 4'h0) begin failures++; $display("[TB] FAIL reset_mul_ops: got %h/%h expected 0/0", mul_M, mul_Q); end
    step();
    reset = 1'b1;
    step();
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
  endtask

  task automatic test_single();
    int t;
    clear_mon();
    out_ready = 1'b1;
    t = cyc;
    in_valid = 1'b1; in_m = 4'h7; in_q = 4'h3;
    step();
    in_valid = 1'b0;
    wait_results(1, 40);
    checks++; if (res_q.size() != 1) begin failures++; $display("[TB] FAIL single_count: got %0d expected 1", res_q.size()); end
    checks++; if (get_res(0) !== 8'h15) begin failures++; $display("[TB] FAIL single_out_p: got %h expected 15", get_res(0)); end
    checks++; if (get_res_cyc(0) - t != 9) begin failures++; $display("[TB] FAIL single_out_latency: got %0d expected 9", get_res_cyc(0) - t); end
    checks++; if (load_cyc.size() != 1) begin failures++; $display("[TB] FAIL single_load_pulses: got %0d expected 1", load_cyc.size()); end
    checks++; if (get_load_cyc(0) - t != 2) begin failures++; $display("[TB] FAIL single_load_latency: got %0d expected 2", get_load_cyc(0) - t); end
    checks++; if (mul_M !== 4'h7 || mul_Q !== 4'h3) begin failures++; $display("[TB] FAIL single_mul_ops: got %h/%h expected 7/3", mul_M, mul_Q); end
  endtask

  task automatic test_back_to_back();
    logic [3:0] bm [4];
    logic [3:0] bq [4];
    logic [7:0] be [4];
    int t;
    bm = '{4'hE, 4'h8, 4'h0, 4'hF};
    bq = '{4'h3, 4'h8, 4'h5, 4'hF};
    be = '{8'hFA, 8'h40, 8'h00, 8'h01};
    clear_mon();
    out_ready = 1'b1;
    t = cyc;
    for (int i = 0; i < 4; i++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL b2b_in_ready[%0d]: got %b expected 1", i, in_ready); end
      in_valid = 1'b1; in_m = bm[i]; in_q = bq[i];
      step();
    end
    in_valid = 1'b0;
    wait_results(4, 100);
    checks++; if (res_q.size() != 4) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (get_res(i) !== be[i]) begin failures++; $display("[TB] FAIL b2b_result[%0d]: got %h expected %h", i, get_res(i), be[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      checks++; if (get_res_cyc(i + 1) - get_res_cyc(i) != MUL_CYCLES + 3) begin
        failures++; $display("[TB] FAIL b2b_spacing[%0d]: got %0d expected %0d", i, get_res_cyc(i + 1) - get_res_cyc(i), MUL_CYCLES + 3);
      end
    end
    checks++; if (get_res_cyc(0) - t != 9) begin failures++; $display("[TB] FAIL b2b_first_latency: got %0d expected 9", get_res_cyc(0) - t); end
    checks++; if (max_level != 3) begin failures++; $display("[TB] FAIL b2b_level_peak: got %0d expected 3", max_level); end
  endtask

  task automatic test_full();
    logic [3:0] fm [6];
    logic [3:0] fq [6];
    logic [7:0] fe [6];
    int k;
    fm = '{4'h1, 4'h2, 4'hD, 4'h4, 4'hB, 4'h7};
    fq = '{4'h1, 4'h3, 4'h2, 4'hC, 4'hD, 4'h8};
    fe = '{8'h01, 8'h06, 8'hFA, 8'hF0, 8'h0F, 8'hC8};
    clear_mon();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_in_ready[%0d]: got %b expected 1", i, in_ready); end
      in_valid = 1'b1; in_m = fm[i]; in_q = fq[i];
      step();
    end
    in_m = fm[5]; in_q = fq[5];
    checks++; if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_in_ready_drop: got %b expected 0", in_ready); end
    checks++; if (level !== 3'd4) begin failures++; $display("[TB] FAIL full_level: got %0d expected 4", level); end
    repeat (20) step();
    checks++; if (level !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("[TB] FAIL full_hold: got level %0d ready %b expected 4 0", level, in_ready); end
    checks++; if (load_cyc.size() != 1) begin failures++; $display("[TB] FAIL full_no_new_load: got %0d expected 1", load_cyc.size()); end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL full_out_valid_held: got %b expected 1", out_valid); end
    out_ready = 1'b1;
    k = 0;
    while (in_ready !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL full_release: got %b expected 1", in_ready); end
    step();
    in_valid = 1'b0;
    wait_results(6, 200);
    checks++; if (res_q.size() != 6) begin failures++; $display("[TB] FAIL full_count: got %0d expected 6", res_q.size()); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (get_res(i) !== fe[i]) begin failures++; $display("[TB] FAIL full_result[%0d]: got %h expected %h", i, get_res(i), fe[i]); end
    end
  endtask

  task automatic test_simul_push_pop();
    logic [3:0] sm [4];
    logic [3:0] sq [4];
    logic [7:0] se [4];
    int k;
    sm = '{4'h1, 4'h3, 4'hC, 4'h5};
    sq = '{4'h2, 4'h3, 4'h2, 4'hF};
    se = '{8'h02, 8'h09, 8'hF8, 8'hFB};
    clear_mon();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_m = sm[i]; in_q = sq[i];
      step();
    end
    in_valid = 1'b0;
    k = 0;
    while (out_valid !== 1'b1 && k < 30) begin
      step();
      k++;
    end
    checks++; if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL spp_wait_done: got %b expected 1", out_valid); end
    checks++; if (level !== 3'd2) begin failures++; $display("[TB] FAIL spp_level_before: got %0d expected 2", level); end
    out_ready = 1'b1;
    step();
    checks++; if (busy !== 1'b0) begin failures++; $display("[TB] FAIL spp_idle: got busy %b expected 0", busy); end
    in_valid = 1'b1; in_m = sm[3]; in_q = sq[3];
    step();
    in_valid = 1'b0;
    checks++; if (level !== 3'd2) begin failures++; $display("[TB] FAIL spp_level_after: got %0d expected 2", level); end
    checks++; if (mul_load !== 1'b1) begin failures++; $display("[TB] FAIL spp_pop_load: got %b expected 1", mul_load); end
    wait_results(4, 100);
    checks++; if (res_q.size() != 4) begin failures++; $display("[TB] FAIL spp_count: got %0d expected 4", res_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (get_res(i) !== se[i]) begin failures++; $display("[TB] FAIL spp_result[%0d]: got %h expected %h", i, get_res(i), se[i]); end
    end
  endtask

  task automatic test_reset_mid_job();
    clear_mon();
    out_ready = 1'b1;
    in_valid = 1'b1; in_m = 4'h2; in_q = 4'h2; step();
    in_m = 4'h3; in_q = 4'h1; step();
    in_m = 4'h1; in_q = 4'h3; step();
    in_valid = 1'b0;
    checks++; if (level !== 3'd2 || busy !== 1'b1) begin failures++; $display("[TB] FAIL rst_pre: got level %0d busy %b expected 2 1", level, busy); end
    step();
    #2;
    reset = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || mul_load !== 1'b0) begin failures++; $display("[TB] FAIL rst_async_outs: got valid %b load %b expected 0 0", out_valid, mul_load); end
    checks++; if (busy !== 1'b0 || level !== 3'd0) begin failures++; $display("[TB] FAIL rst_async_state: got busy %b level %0d expected 0 0", busy, level); end
    step();
    reset = 1'b1;
    clear_mon();
    repeat (20) step();
    checks++; if (res_q.size() != 0 || load_cyc.size() != 0) begin failures++; $display("[TB] FAIL rst_no_stale: got %0d results %0d loads expected 0 0", res_q.size(), load_cyc.size()); end
    checks++; if (busy !== 1'b0 || level !== 3'd0 || out_valid !== 1'b0 || out_p !== 8'h00) begin
      failures++; $display("[TB] FAIL rst_idle: got busy %b level %0d valid %b p %h expected 0 0 0 00", busy, level, out_valid, out_p);
    end
  endtask

  task automatic test_mulp_window();
    int t;
    clear_mon();
    out_ready = 1'b1;
    t = cyc;
    in_valid = 1'b1; in_m = 4'h9; in_q = 4'h5;
    step();
    in_valid = 1'b0;
    wait_results(1, 40);
    checks++; if (get_res(0) !== 8'hDD) begin failures++; $display("[TB] FAIL window_out_p: got %h expected DD", get_res(0)); end
    checks++; if (get_res_cyc(0) - t != 9) begin failures++; $display("[TB] FAIL window_latency: got %0d expected 9", get_res_cyc(0) - t); end
    checks++; if (stable_err != 0) begin failures++; $display("[TB] FAIL window_ops_stable: got %0d changes expected 0", stable_err); end
    checks++; if (mul_M !== 4'h9 || mul_Q !== 4'h5) begin failures++; $display("[TB] FAIL window_mul_ops: got %h/%h expected 9/5", mul_M, mul_Q); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_simul_push_pop();
    test_reset_mid_job();
    test_mulp_window();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
